// File: rtl/ssr_select_ctrl.sv
// ssr_select_ctrl: antenna-selection sequencer.
// Collects WINDOW sample vectors and accumulates |x|^2 per antenna through one
// shared squaring datapath, one antenna per cycle. It then scans the
// accumulators and reports the strongest antenna. Ties go to the lowest index.
// Optional build macro SSR_SATURATE_EN: when it is defined, the accumulators
// saturate at all-ones. When it is undefined, the accumulators wrap.
module ssr_select_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ANTENA_NUM = 4,
  parameter int WINDOW     = 16,
  parameter int ACC_WIDTH  = 68,
  parameter int IDX_WIDTH  = $clog2(ANTENA_NUM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [ANTENA_NUM*DATA_WIDTH-1:0] real_part,
  input  logic [ANTENA_NUM*DATA_WIDTH-1:0] imag_part,
  output logic                             busy,
  output logic                             sel_valid,
  output logic [IDX_WIDTH-1:0]             sel_idx,
  output logic [ACC_WIDTH-1:0]             sel_energy
);

  localparam int SQ_W  = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(WINDOW + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_CALC = 3'd2,
    ST_SCAN = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t                        r_state;
  state_t                        w_next_state;
  logic signed [DATA_WIDTH-1:0]  r_re [ANTENA_NUM];
  logic signed [DATA_WIDTH-1:0]  r_im [ANTENA_NUM];
  logic [ACC_WIDTH-1:0]          r_acc [ANTENA_NUM];
  logic [IDX_WIDTH-1:0]          r_ant_cnt;
  logic [CNT_W-1:0]              r_sample_cnt;
  logic [ACC_WIDTH-1:0]          r_best;
  logic [IDX_WIDTH-1:0]          r_best_idx;
  logic                          r_in_ready;
  logic                          r_busy;
  logic                          r_sel_valid;
  logic [IDX_WIDTH-1:0]          r_sel_idx;
  logic [ACC_WIDTH-1:0]          r_sel_energy;

  logic                          w_last_ant;
  logic                          w_last_sample;
  logic [SQ_W-1:0]               w_mag;
  logic [ACC_WIDTH-1:0]          w_acc_next;
  logic [ACC_WIDTH-1:0]          w_best_next;
  logic [IDX_WIDTH-1:0]          w_best_idx_next;

  // re^2 + im^2. Each square is exact in SQ_W signed bits, including the
  // most-negative input. The sum needs all SQ_W bits as an unsigned value.
  function automatic logic [SQ_W-1:0] mag_sq(input logic signed [DATA_WIDTH-1:0] re,
                                             input logic signed [DATA_WIDTH-1:0] im);
    logic signed [SQ_W-1:0] re_sq;
    logic signed [SQ_W-1:0] im_sq;
    re_sq  = SQ_W'(re) * SQ_W'(re);
    im_sq  = SQ_W'(im) * SQ_W'(im);
    mag_sq = $unsigned(re_sq) + $unsigned(im_sq);
  endfunction

`ifdef SSR_SATURATE_EN
  localparam int SUM_W = ((ACC_WIDTH > SQ_W) ? ACC_WIDTH : SQ_W) + 1;

  // Accumulator add that clamps at all-ones instead of wrapping.
  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic [SQ_W-1:0]      mag);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(mag);
    if (|sum[SUM_W-1:ACC_WIDTH]) begin
      acc_add = '1;
    end else begin
      acc_add = sum[ACC_WIDTH-1:0];
    end
  endfunction
`else
  // Accumulator add modulo 2^ACC_WIDTH.
  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] acc,
                                                   input logic [SQ_W-1:0]      mag);
    acc_add = acc + ACC_WIDTH'(mag);
  endfunction
`endif

  assign w_last_ant    = (r_ant_cnt == IDX_WIDTH'(ANTENA_NUM - 1));
  assign w_last_sample = (r_sample_cnt == CNT_W'(WINDOW - 1));
  assign w_mag         = mag_sq(r_re[r_ant_cnt], r_im[r_ant_cnt]);
  assign w_acc_next    = acc_add(r_acc[r_ant_cnt], w_mag);

  // Scan compare: the first index seeds best, and later indices win only when strictly greater.
  always_comb begin
    w_best_next     = r_best;
    w_best_idx_next = r_best_idx;
    if ((r_ant_cnt == IDX_WIDTH'(0)) || (r_acc[r_ant_cnt] > r_best)) begin
      w_best_next     = r_acc[r_ant_cnt];
      w_best_idx_next = r_ant_cnt;
    end else begin
      w_best_next     = r_best;
      w_best_idx_next = r_best_idx;
    end
  end

  // Next-state logic for the window sequencer.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_LOAD;
        else       w_next_state = ST_IDLE;
      end
      ST_LOAD: begin
        if (in_valid) w_next_state = ST_CALC;
        else          w_next_state = ST_LOAD;
      end
      ST_CALC: begin
        if (w_last_ant && w_last_sample) w_next_state = ST_SCAN;
        else if (w_last_ant)             w_next_state = ST_LOAD;
        else                             w_next_state = ST_CALC;
      end
      ST_SCAN: begin
        if (w_last_ant) w_next_state = ST_DONE;
        else            w_next_state = ST_SCAN;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Datapath: vector capture, per-antenna accumulation, scan and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ANTENA_NUM; i++) begin
        r_re[i]  <= '0;
        r_im[i]  <= '0;
        r_acc[i] <= '0;
      end
      r_ant_cnt    <= '0;
      r_sample_cnt <= '0;
      r_best       <= '0;
      r_best_idx   <= '0;
      r_sel_idx    <= '0;
      r_sel_energy <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < ANTENA_NUM; i++) r_acc[i] <= '0;
            r_sample_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            for (int i = 0; i < ANTENA_NUM; i++) begin
              r_re[i] <= real_part[i*DATA_WIDTH +: DATA_WIDTH];
              r_im[i] <= imag_part[i*DATA_WIDTH +: DATA_WIDTH];
            end
            r_ant_cnt <= '0;
          end
        end
        ST_CALC: begin
          r_acc[r_ant_cnt] <= w_acc_next;
          if (w_last_ant) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            r_ant_cnt    <= '0;
          end else begin
            r_ant_cnt    <= r_ant_cnt + IDX_WIDTH'(1);
          end
        end
        ST_SCAN: begin
          r_best     <= w_best_next;
          r_best_idx <= w_best_idx_next;
          if (w_last_ant) begin
            // Result is captured on entry to DONE so it is valid alongside sel_valid.
            r_sel_idx    <= w_best_idx_next;
            r_sel_energy <= w_best_next;
            r_ant_cnt    <= '0;
          end else begin
            r_ant_cnt    <= r_ant_cnt + IDX_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags registered from the next state, so each one equals a decode of the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_sel_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == ST_LOAD);
      r_busy      <= (w_next_state != ST_IDLE);
      r_sel_valid <= (w_next_state == ST_DONE);
    end
  end

  assign in_ready   = r_in_ready;
  assign busy       = r_busy;
  assign sel_valid  = r_sel_valid;
  assign sel_idx    = r_sel_idx;
  assign sel_energy = r_sel_energy;

endmodule

// File: tb/tb_ssr_select_ctrl.sv
// Directed bench for ssr_select_ctrl. Instance u_dut uses the default
// parameters. Instance u_sat uses ACC_WIDTH=8 and checks saturation or wrap,
// depending on SSR_SATURATE_EN.
module tb_ssr_select_ctrl;

  localparam int DW  = 32;
  localparam int AN  = 4;
  localparam int WIN = 16;
  localparam int AW  = 68;
  localparam int IW  = 2;
  localparam int AW2 = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            start2 = 1'b0;
  logic            in_valid = 1'b0;
  logic [AN*DW-1:0] real_part = '0;
  logic [AN*DW-1:0] imag_part = '0;

  logic            in_ready, busy, sel_valid;
  logic [IW-1:0]   sel_idx;
  logic [AW-1:0]   sel_energy;
  logic            in_ready2, busy2, sel_valid2;
  logic [IW-1:0]   sel_idx2;
  logic [AW2-1:0]  sel_energy2;

  int tests = 0;
  int fails = 0;

  ssr_select_ctrl #(.DATA_WIDTH(DW), .ANTENA_NUM(AN), .WINDOW(WIN), .ACC_WIDTH(AW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .real_part(real_part), .imag_part(imag_part), .busy(busy), .sel_valid(sel_valid),
    .sel_idx(sel_idx), .sel_energy(sel_energy)
  );

  ssr_select_ctrl #(.DATA_WIDTH(DW), .ANTENA_NUM(AN), .WINDOW(WIN), .ACC_WIDTH(AW2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .real_part(real_part), .imag_part(imag_part), .busy(busy2), .sel_valid(sel_valid2),
    .sel_idx(sel_idx2), .sel_energy(sel_energy2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AN*DW-1:0] vec(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                           input logic [DW-1:0] a2, input logic [DW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit which);
    if (which) start2 = 1'b1;
    else       start  = 1'b1;
    tick();
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  // Offer one vector after `gap` idle cycles and return one cycle after the handshake edge.
  task automatic send(input bit which, input logic [AN*DW-1:0] re, input logic [AN*DW-1:0] im,
                      input int gap, input bit poke_start);
    int g = 0;
    in_valid = 1'b0;
    for (int i = 0; i < gap; i++) tick();
    real_part = re;
    imag_part = im;
    in_valid  = 1'b1;
    while (((which ? in_ready2 : in_ready) !== 1'b1) && (g < 50)) begin
      tick();
      g++;
    end
    if (g >= 50) chk("ready_timeout", 128'(g), 128'(0));
    tick();
    in_valid = 1'b0;
    if (poke_start) begin
      chk("ready_low_in_calc", 128'(in_ready), 128'(0));
      chk("busy_in_calc", 128'(busy), 128'(1));
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic wait_result(input bit which, input string tag, input logic [IW-1:0] eidx,
                             input logic [127:0] eeng);
    int n = 0;
    while (((which ? sel_valid2 : sel_valid) !== 1'b1) && (n < 40)) begin
      tick();
      n++;
    end
    // Four CALC cycles for the last vector, then four SCAN cycles, then DONE.
    chk({tag, "_latency"}, 128'(n), 128'(8));
    chk({tag, "_idx"}, 128'(which ? sel_idx2 : sel_idx), 128'(eidx));
    chk({tag, "_energy"}, which ? 128'(sel_energy2) : 128'(sel_energy), eeng);
    tick();
    chk({tag, "_pulse_one_cycle"}, 128'(which ? sel_valid2 : sel_valid), 128'(0));
    chk({tag, "_idx_held"}, 128'(which ? sel_idx2 : sel_idx), 128'(eidx));
    chk({tag, "_idle_after"}, 128'(which ? busy2 : busy), 128'(0));
  endtask

  initial begin
    bit bad;

    // Reset values.
    repeat (3) tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_sel_valid", 128'(sel_valid), 128'(0));
    chk("rst_sel_idx", 128'(sel_idx), 128'(0));
    chk("rst_sel_energy", 128'(sel_energy), 128'(0));
    rst_n = 1'b1;
    tick();

    // Idle without start: in_valid activity must be ignored.
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = i[0];
      tick();
      if (sel_valid || busy || in_ready || busy2) bad = 1'b1;
    end
    in_valid = 1'b0;
    chk("idle_quiet", 128'(bad), 128'(0));

    // Antenna 2 strongest: 16 * (9 + 16) = 400.
    pulse_start(1'b0);
    chk("busy_after_start", 128'(busy), 128'(1));
    for (int i = 0; i < WIN; i++) send(1'b0, vec(1, 1, 3, 1), vec(1, 1, 4, 1), 0, 1'b0);
    wait_result(1'b0, "strong2", 2'd2, 128'd400);

    // Start in the cycle after DONE, with all-zero data.
    pulse_start(1'b0);
    chk("restart_after_done", 128'(busy), 128'(1));
    for (int i = 0; i < WIN; i++) send(1'b0, '0, '0, 0, 1'b0);
    wait_result(1'b0, "zeros", 2'd0, 128'd0);

    // Tie between antennas 1 and 3: 16 * 4 = 64, lowest index wins.
    pulse_start(1'b0);
    for (int i = 0; i < WIN; i++) send(1'b0, vec(0, 2, 0, 2), '0, 0, 1'b0);
    wait_result(1'b0, "tie", 2'd1, 128'd64);

    // Gaps on in_valid, plus a stray start during CALC: 16 * (25 + 49) = 1184.
    pulse_start(1'b0);
    for (int i = 0; i < WIN; i++)
      send(1'b0, vec(1, 1, 1, 32'hFFFF_FFFB), vec(0, 0, 0, 7), $urandom_range(0, 3), (i == 5));
    wait_result(1'b0, "backpressure", 2'd3, 128'd1184);

    // Reset after 7 vectors discards the window and clears the result.
    pulse_start(1'b0);
    for (int i = 0; i < 7; i++) send(1'b0, vec(9, 9, 9, 9), '0, 0, 1'b0);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    chk("midrst_sel_idx", 128'(sel_idx), 128'(0));
    chk("midrst_sel_energy", 128'(sel_energy), 128'(0));
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (sel_valid || busy) bad = 1'b1;
    end
    chk("midrst_no_result", 128'(bad), 128'(0));

    // Most-negative real sample on antenna 0: 16 * 2^62 = 2^66.
    pulse_start(1'b0);
    for (int i = 0; i < WIN; i++) send(1'b0, vec(32'h8000_0000, 0, 0, 0), '0, 0, 1'b0);
    wait_result(1'b0, "mostneg", 2'd0, 128'd1 << 66);

    // ACC_WIDTH=8 instance: 16 * 100 = 1600 saturates to 255, or wraps to 64.
    pulse_start(1'b1);
    for (int i = 0; i < WIN; i++) send(1'b1, vec(10, 0, 0, 0), '0, 0, 1'b0);
`ifdef SSR_SATURATE_EN
    wait_result(1'b1, "acc8", 2'd0, 128'd255);
`else
    wait_result(1'b1, "acc8", 2'd0, 128'd64);
`endif
    chk("acc8_main_idle", 128'(busy), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssr_select_ctrl.md
Name: ssr_select_ctrl

Overview:
- Sequencer for antenna selection.
- Collects WINDOW sample vectors, each holding one complex sample per antenna.
- Time-multiplexes one shared magnitude-squared datapath (re*re + im*im) across the ANTENA_NUM antennas and accumulates per-antenna energy.
- When the window ends, scans the accumulators and reports the strongest antenna and its energy to the downstream switch control.

Parameters:
- DATA_WIDTH, 32, width of each signed real/imag sample.
- ANTENA_NUM, 4, number of antennas; must be >= 2.
- WINDOW, 16, sample vectors per selection; must be >= 1.
- ACC_WIDTH, 68, width of each unsigned energy accumulator (2*DATA_WIDTH + clog2(WINDOW) is wrap-free).
- IDX_WIDTH, clog2(ANTENA_NUM), width of the antenna index.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a selection window; sampled only in IDLE.
- in_valid  in  1  sample vector valid.
- in_ready  out  1  block accepts a vector this cycle.
- real_part  in  ANTENA_NUM*DATA_WIDTH  signed real samples; antenna i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- imag_part  in  ANTENA_NUM*DATA_WIDTH  signed imaginary samples, same packing.
- busy  out  1  high in every state except IDLE.
- sel_valid  out  1  one-cycle pulse: result valid.
- sel_idx  out  IDX_WIDTH  selected antenna; held until the next DONE.
- sel_energy  out  ACC_WIDTH  accumulated energy of sel_idx; held until the next DONE.

Behaviour:
- Reset (async assert, sync deassert):
  - State IDLE.
  - in_ready, busy, sel_valid = 0; sel_idx = 0; sel_energy = 0.
  - All accumulators and counters = 0.
- FSM states: IDLE, LOAD, CALC, SCAN, DONE.
- IDLE:
  - start=1 -> clear all accumulators and sample_cnt, go to LOAD.
  - in_valid is ignored.
- LOAD:
  - in_ready=1.
  - When in_valid && in_ready, register both vectors, set ant_cnt=0, go to CALC.
  - in_ready is combinational from state only; it never depends on in_valid.
- CALC:
  - One antenna per cycle: acc[ant_cnt] += re^2 + im^2, computed signed then zero-extended to ACC_WIDTH.
  - Each square is 2*DATA_WIDTH bits; the sum is 2*DATA_WIDTH unsigned bits. The most-negative input squared is exact.
  - When ant_cnt reaches ANTENA_NUM-1, increment sample_cnt:
    - sample_cnt reaches WINDOW -> go to SCAN.
    - otherwise -> go to LOAD.
  - Cost: ANTENA_NUM cycles per vector. Throughput is one vector per ANTENA_NUM+1 cycles with in_valid held high.
- SCAN:
  - One accumulator compared per cycle, ANTENA_NUM cycles total.
  - best starts as acc[0]; index k replaces best only if acc[k] > best (strictly greater), so ties go to the lowest index.
  - Then go to DONE.
- DONE:
  - Load sel_idx and sel_energy; sel_valid=1 for exactly this cycle.
  - Then go to IDLE.
- Latency: the sel_valid edge occurs ANTENA_NUM+1 cycles after the CALC cycle of the last antenna of the last vector.
- Arithmetic: without the optional feature, the accumulator wraps modulo 2^ACC_WIDTH.
- Boundaries:
  - start outside IDLE is ignored; no restart mid-window.
  - WINDOW=1: a single LOAD/CALC pass, then SCAN.
  - All-zero inputs -> sel_idx=0, sel_energy=0.
  - Reset mid-window discards partial accumulation; no sel_valid is produced.
  - start may arrive the cycle after DONE (in IDLE) and is honoured.

Optional Feature:
- Macro: SSR_SATURATE_EN.
- Defined: every accumulator add saturates at 2^ACC_WIDTH-1 instead of wrapping. A saturated accumulator still takes part in SCAN; ties among saturated values go to the lowest index.
- Undefined: plain modulo-2^ACC_WIDTH add.

Test Plan:
- Reset then idle, WINDOW=16, ANTENA_NUM=4: busy=0, in_ready=0, sel_valid never asserts without start.
- Single window, 16 vectors, every sample re=3, im=4 on antenna 2, all others 1,1 -> sel_idx=2, sel_energy=400, one-cycle sel_valid.
- Tie: antennas 1 and 3 both re=2, im=0 per sample, others 0 -> sel_idx=1, sel_energy=64.
- Backpressure: in_valid toggled randomly, plus start pulsed during CALC -> the extra start is ignored, result is unchanged, and in_ready is high only in LOAD.
- rst_n pulsed low after 7 vectors, then a fresh window with antenna 0 at re=-2^31, im=0 -> sel_idx=0, sel_energy=16*2^62=2^66.
- SSR_SATURATE_EN with ACC_WIDTH=8, antenna 0 re=10, im=0, WINDOW=16 -> sel_energy=255; same case without the macro -> 1600 mod 256 = 64.
